// File: rtl/mem_initiator.sv
// Load/store initiator for the word RAM: sub-word stores go through read-modify-write,
// loads return zero-extended big-endian lanes. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_initiator #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata,
  input  logic                  i_mem_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

  logic [2:0]  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((i_size == 2'b01) && i_addr[0]) ||
                      (i_size[1] && (i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Big-endian: byte offset 0 lives in bits [31:24].
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r = {24'b0, w[31:24]};
          2'd1:    r = {24'b0, w[23:16]};
          2'd2:    r = {24'b0, w[15:8]};
          default: r = {24'b0, w[7:0]};
        endcase
      end
      2'b01:   r = off[1] ? {16'b0, w[15:0]} : {16'b0, w[31:16]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r = {d[7:0], w[23:0]};
          2'd1:    r = {w[31:24], d[7:0], w[15:0]};
          2'd2:    r = {w[31:16], d[7:0], w[7:0]};
          default: r = {w[31:8], d[7:0]};
        endcase
      end
      2'b01:   r = off[1] ? {w[31:16], d} : {d, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      o_busy      <= 1'b0;
      o_ack       <= 1'b0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_ack       <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            we_q       <= i_we;
            size_q     <= i_size;
            off_q      <= i_addr[1:0];
            wdata_q    <= i_wdata[15:0];
            o_mem_addr <= i_addr[ADDR_WIDTH+1:2];
            if (misaligned) begin
              o_ack   <= 1'b1;
              o_err   <= 1'b1;
              o_rdata <= '0;
            end else if (i_we && i_size[1]) begin
              state       <= S_WR;
              o_busy      <= 1'b1;
              o_mem_write <= 1'b1;
              o_mem_wdata <= i_wdata;
            end else begin
              state      <= S_RD;
              o_busy     <= 1'b1;
              o_mem_read <= 1'b1;
            end
          end
        end
        S_RD: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (i_mem_done) begin
            if (!we_q) begin
              o_rdata <= lane_extract(i_mem_rdata, size_q, off_q);
              o_ack   <= 1'b1;
              o_busy  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              // Sub-word store: splice the new lane into the word just read.
              o_mem_wdata <= lane_merge(i_mem_rdata, wdata_q, size_q, off_q);
              o_mem_write <= 1'b1;
              state       <= S_WR;
            end
          end
        end
        S_WR: state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (i_mem_done) begin
            o_ack  <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed vector bench for mem_initiator with a small one-cycle RAM model.
module tb_mem_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [21:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_busy, o_ack, o_err, o_mem_read, o_mem_write;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [19:0] o_mem_addr;
  logic [31:0] ram_rdata = '0;
  logic        ram_done = 1'b0, stray = 1'b0;
  logic [31:0] ram [0:255];
  int          n_rd = 0, n_wr = 0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_initiator #(.ADDR_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_ack(o_ack),
    .o_rdata(o_rdata), .o_err(o_err), .o_mem_addr(o_mem_addr),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(ram_rdata), .i_mem_done(ram_done | stray)
  );

  always @(posedge clk) begin
    ram_done <= o_mem_read | o_mem_write;
    if (o_mem_read) ram_rdata <= ram[o_mem_addr[7:0]];
    if (o_mem_write) ram[o_mem_addr[7:0]] <= o_mem_wdata;
    if (o_mem_read) n_rd <= n_rd + 1;
    if (o_mem_write) n_wr <= n_wr + 1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [21:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [19:0] maddr;
    logic [31:0] ram;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'h0);
    chk({tag, "_ack"}, {31'b0, o_ack}, 32'h0);
    chk({tag, "_err"}, {31'b0, o_err}, 32'h0);
    chk({tag, "_rdata"}, o_rdata, 32'h0);
    chk({tag, "_maddr"}, {12'b0, o_mem_addr}, 32'h0);
    chk({tag, "_strobes"}, {30'b0, o_mem_read, o_mem_write}, 32'h0);
    chk({tag, "_mwdata"}, o_mem_wdata, 32'h0);
  endtask

  // Latency counts clock edges from the accept edge (inclusive) to the edge raising o_ack.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic [21:0] a,
                       input logic [31:0] wd, output int lat);
    @(negedge clk);
    i_req = 1'b1; i_we = we; i_size = sz; i_addr = a; i_wdata = wd;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      i_req = 1'b0;
      if (o_ack) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat, r0, w0;
    logic any_ack;
    vecs[0]  = '{1'b1, 2'b10, 22'h100, 32'hDEADBEEF, 1'b0, 32'h0,        3, 0, 1, 20'h40, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 22'h100, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 0, 20'h40, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b10, 22'h100, 32'h11223344, 1'b0, 32'h0,        3, 0, 1, 20'h40, 32'h11223344};
    vecs[3]  = '{1'b1, 2'b00, 22'h102, 32'h000000AA, 1'b0, 32'h0,        5, 1, 1, 20'h40, 32'h1122AA44};
    vecs[4]  = '{1'b1, 2'b10, 22'h100, 32'h11223344, 1'b0, 32'h0,        3, 0, 1, 20'h40, 32'h11223344};
    vecs[5]  = '{1'b0, 2'b00, 22'h101, 32'h0,        1'b0, 32'h00000022, 3, 1, 0, 20'h40, 32'h11223344};
    vecs[6]  = '{1'b0, 2'b01, 22'h102, 32'h0,        1'b0, 32'h00003344, 3, 1, 0, 20'h40, 32'h11223344};
    vecs[7]  = '{1'b0, 2'b01, 22'h100, 32'h0,        1'b0, 32'h00001122, 3, 1, 0, 20'h40, 32'h11223344};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[8]  = '{1'b0, 2'b01, 22'h101, 32'h0,        1'b1, 32'h0,        1, 0, 0, 20'h40, 32'h11223344};
`else
    vecs[8]  = '{1'b0, 2'b01, 22'h101, 32'h0,        1'b0, 32'h00001122, 3, 1, 0, 20'h40, 32'h11223344};
`endif
    vecs[9]  = '{1'b1, 2'b01, 22'h102, 32'h0000BEEF, 1'b0, 32'h0,        5, 1, 1, 20'h40, 32'h1122BEEF};
    vecs[10] = '{1'b1, 2'b00, 22'h103, 32'h00000055, 1'b0, 32'h0,        5, 1, 1, 20'h40, 32'h1122BE55};
    vecs[11] = '{1'b0, 2'b00, 22'h100, 32'h0,        1'b0, 32'h00000011, 3, 1, 0, 20'h40, 32'h1122BE55};
    vecs[12] = '{1'b0, 2'b11, 22'h100, 32'h0,        1'b0, 32'h1122BE55, 3, 1, 0, 20'h40, 32'h1122BE55};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[13] = '{1'b0, 2'b10, 22'h103, 32'h0,        1'b1, 32'h0,        1, 0, 0, 20'h40, 32'h1122BE55};
`else
    vecs[13] = '{1'b0, 2'b10, 22'h103, 32'h0,        1'b0, 32'h1122BE55, 3, 1, 0, 20'h40, 32'h1122BE55};
`endif
    vecs[14] = '{1'b1, 2'b00, 22'h101, 32'hFFFFF1FF, 1'b0, 32'h0,        5, 1, 1, 20'h40, 32'h11FFBE55};
    vecs[15] = '{1'b1, 2'b10, 22'h204, 32'hCAFEF00D, 1'b0, 32'h0,        3, 0, 1, 20'h81, 32'hCAFEF00D};
    vecs[16] = '{1'b0, 2'b10, 22'h204, 32'h0,        1'b0, 32'hCAFEF00D, 3, 1, 0, 20'h81, 32'hCAFEF00D};

    repeat (2) @(posedge clk);
    #1 chk_idle_zero("reset");
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      r0 = n_rd; w0 = n_wr;
      do_op(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, o_err}, {31'b0, vecs[i].err});
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), o_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_nrd", i), n_rd - r0, vecs[i].nrd);
      chk($sformatf("v%0d_nwr", i), n_wr - w0, vecs[i].nwr);
      chk($sformatf("v%0d_maddr", i), {12'b0, o_mem_addr}, {12'b0, vecs[i].maddr});
      chk($sformatf("v%0d_ram", i), ram[vecs[i].maddr[7:0]], vecs[i].ram);
    end

    // Back-to-back: request raised in the ack cycle, then held during busy.
    do_op(1'b0, 2'b10, 22'h100, 32'h0, lat);
    chk("b2b_first_lat", lat, 3);
    r0 = n_rd; w0 = n_wr;
    i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = 22'h204; i_wdata = 32'h0;
    @(posedge clk); #1;
    chk("b2b_busy", {31'b0, o_busy}, 32'h1);
    chk("b2b_read", {31'b0, o_mem_read}, 32'h1);
    chk("b2b_maddr", {12'b0, o_mem_addr}, 32'h81);
    i_we = 1'b1; i_size = 2'b00; i_addr = 22'h100; i_wdata = 32'h99;
    @(posedge clk); #1;
    i_req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack", {31'b0, o_ack}, 32'h1);
    chk("b2b_rdata", o_rdata, 32'hCAFEF00D);
    chk("b2b_nrd", n_rd - r0, 1);
    chk("b2b_nwr", n_wr - w0, 0);
    repeat (3) @(posedge clk);
    #1 chk("b2b_no_extra", n_rd - r0 + n_wr - w0, 1);
    chk("b2b_ram", ram[8'h40], 32'h11FFBE55);

    // Reset in RD_WAIT of a byte RMW, then a stray done.
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b00; i_addr = 22'h100; i_wdata = 32'h77;
    w0 = n_wr;
    @(posedge clk); #1 i_req = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1 chk_idle_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    any_ack = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_ack || o_busy) any_ack = 1'b1;
    end
    chk("stray_ignored", {31'b0, any_ack}, 32'h0);
    chk("midrst_nwr", n_wr - w0, 0);
    chk("midrst_ram", ram[8'h40], 32'h11FFBE55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Memory-side initiator for the 1M x 32 word RAM. Accepts byte-addressed CPU loads and stores of byte, halfword or word size.
- Issues single-cycle read/write strobes to the RAM port and waits for its registered done.
- Performs read-modify-write for sub-word stores and returns lane-extracted, zero-extended load data.
- Sits between the ZPU core's load/store unit and the RAM. Big-endian lane order.

Parameters:
ADDR_WIDTH, 20, word address width on the RAM side (CPU byte address is ADDR_WIDTH+2 bits)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
i_req  input  1  request strobe, sampled only when o_busy=0
i_we  input  1  1=store, 0=load
i_size  input  2  00=byte, 01=halfword, 10=word, 11=treated as word
i_addr  input  ADDR_WIDTH+2  byte address
i_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
o_busy  output  1  request in progress (state != IDLE)
o_ack  output  1  one-cycle completion pulse
o_rdata  output  32  load result, zero-extended; valid while o_ack=1, held until next ack
o_err  output  1  alignment error pulse, coincident with o_ack (constant 0 without feature)
o_mem_addr  output  ADDR_WIDTH  RAM word address (i_addr[ADDR_WIDTH+1:2])
o_mem_read  output  1  RAM read strobe, exactly one cycle per op
o_mem_write  output  1  RAM write strobe, exactly one cycle per op
o_mem_wdata  output  32  RAM write data
i_mem_rdata  input  32  RAM read data, valid when i_mem_done=1 after a read
i_mem_done  input  1  RAM completion, one cycle after strobe

Behaviour:
- Reset: state IDLE; all outputs 0, including o_rdata, o_mem_addr and o_mem_wdata. Latched request discarded.
- All outputs registered.
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT.
- Accept: in IDLE with i_req=1, latch we/size/addr/wdata.
  - Load, or sub-word store: -> RD, o_mem_read=1 for that cycle.
  - Word store: -> WR, o_mem_write=1, o_mem_wdata=i_wdata.
- RD/WR last exactly one cycle, then move to *_WAIT with strobes deasserted.
- RD_WAIT on i_mem_done:
  - Load: o_rdata <= extracted lane, o_ack=1 next cycle, -> IDLE.
  - Sub-word store: merge new lane into i_mem_rdata, -> WR.
- WR_WAIT on i_mem_done: o_ack=1 next cycle, -> IDLE.
- Lanes, big-endian:
  - Byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half offset 0 -> [31:16], 2 -> [15:0].
  - Unused bytes of o_rdata are 0.
- Latency from accept edge to o_ack high: load 3 cycles; word store 3; sub-word store 5.
- o_ack is high in the IDLE cycle (o_busy=0). A new i_req in that cycle is accepted (back-to-back allowed).
- i_req while o_busy=1 is ignored, not queued.
- i_mem_done in IDLE (stray, e.g. after reset mid-op) is ignored.
- Misalignment (no feature): halfword ignores addr[0]; word ignores addr[1:0].
- Reset mid-operation: abort immediately. No further strobes; a partially completed RMW leaves RAM unmodified.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, issues no RAM strobe.
  - o_ack=1 and o_err=1 one cycle after accept; o_rdata=0; returns to IDLE.
- Undefined: o_err tied 0; behaviour as in Behaviour.

Test Plan:
- Word store/load: store 0xDEADBEEF to byte addr 0x100 -> one o_mem_write with o_mem_addr=0x40; ack 3 cycles after accept. Load 0x100 -> o_rdata=0xDEADBEEF, ack 3 cycles after accept.
- Byte RMW: RAM[0x40]=0x11223344; store byte 0xAA to addr 0x102 -> read then write 0x1122AA44; exactly one read and one write strobe; ack 5 cycles after accept.
- Sub-word loads: RAM[0x40]=0x11223344. Byte load 0x101 -> 0x00000022. Half load 0x102 -> 0x00003344. Half load 0x100 -> 0x00001122.
- Back-to-back: new i_req asserted in the ack cycle is accepted. i_req during o_busy produces no extra strobe or ack.
- Reset mid-RMW: assert reset in RD_WAIT -> all outputs 0 immediately. Following stray i_mem_done ignored; RAM word unchanged.
- With MEM_ALIGN_CHECK_EN: half load 0x101 -> o_ack=o_err=1 one cycle after accept, no RAM strobe, o_rdata=0. Without the macro: same access returns 0x00001122.
